// File: rtl/div_sequencer.sv
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Start/busy/done handshake with flush abort; special cases finish in one cycle.
module div_sequencer #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CW = (XLEN > 1) ? $clog2(XLEN) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] r_q, r_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            qneg_q, qneg_d;
    logic            rneg_q, rneg_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            in_signed;
    logic            div_zero;
    logic            sgn_ovf;
    logic [XLEN:0]   r_shift;
    logic            r_ge;
    logic [XLEN-1:0] r_diff;
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;

    always_comb begin
        in_signed = ~op[0];
        div_zero  = (divisor == '0);
        sgn_ovf   = in_signed && (dividend == {1'b1, {(XLEN-1){1'b0}}})
                              && (divisor == '1);

        // Partial remainder stays below |divisor| after each step, so only the
        // low XLEN bits of the difference are ever needed.
        r_shift = {r_q, a_q[XLEN-1]};
        r_ge    = (r_shift >= {1'b0, b_q});
        r_diff  = r_shift[XLEN-1:0] - b_q;

        q_fix = qneg_q ? -a_q : a_q;
        r_fix = rneg_q ? -r_q : r_q;

        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        r_d      = r_q;
        cnt_d    = cnt_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        result_d = result_q;

        unique case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    op_d = op;
                    if (div_zero) begin
                        result_d = op[1] ? dividend : '1;
                        state_d  = DONE;
                        done_d   = 1'b1;
                    end else if (sgn_ovf) begin
                        result_d = op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
                        state_d  = DONE;
                        done_d   = 1'b1;
                    end else begin
                        a_d     = (in_signed && dividend[XLEN-1]) ? -dividend : dividend;
                        b_d     = (in_signed && divisor[XLEN-1]) ? -divisor : divisor;
                        r_d     = '0;
                        qneg_d  = in_signed && (dividend[XLEN-1] ^ divisor[XLEN-1]);
                        rneg_d  = in_signed && dividend[XLEN-1];
                        cnt_d   = CW'(XLEN - 1);
                        state_d = CALC;
                        busy_d  = 1'b1;
                    end
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    if (r_ge) begin
                        r_d = r_diff;
                        a_d = {a_q[XLEN-2:0], 1'b1};
                    end else begin
                        r_d = r_shift[XLEN-1:0];
                        a_d = {a_q[XLEN-2:0], 1'b0};
                    end
                    if (cnt_q == '0) begin
                        state_d = FIX;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                    busy_d = 1'b1;
                end
            end
            FIX: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    result_d = op_q[1] ? r_fix : q_fix;
                    state_d  = DONE;
                    done_d   = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            r_q      <= '0;
            cnt_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            r_q      <= r_d;
            cnt_q    <= cnt_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: scoreboard of expected results and latencies,
// plus flush, reset and start-while-busy scenarios.
module tb_div_sequencer;

    localparam int unsigned XLEN = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    int          lat_q[$];

    div_sequencer #(.XLEN(XLEN)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .flush    (flush),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    always #5 clk = ~clk;

    function automatic logic is_special(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
        return (b == 32'h0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        if (b == 32'h0) return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return o[1] ? 32'h0 : 32'h8000_0000;
        case (o)
            2'b00:   return 32'($signed(a) / $signed(b));
            2'b01:   return a / b;
            2'b10:   return 32'($signed(a) % $signed(b));
            default: return a % b;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] golden);
        int cyc;
        logic seen;
        logic [31:0] e;
        int lat;
        exp_q.push_back(model(o, a, b));
        lat_q.push_back(is_special(o, a, b) ? 1 : XLEN + 2);
        @(negedge clk);
        op = o; dividend = a; divisor = b; start = 1'b1;
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                start = 1'b0;
                check({tag, "_busy1"}, 32'(busy), 32'(!is_special(o, a, b)));
                dividend = $urandom;
                divisor = $urandom;
                op = 2'($urandom);
            end
            if (done) seen = 1'b1;
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            e = exp_q.pop_front();
            lat = lat_q.pop_front();
            check({tag, "_result"}, result, e);
            check({tag, "_golden"}, result, golden);
            check({tag, "_latency"}, 32'(cyc), 32'(lat));
            check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        end else begin
            void'(exp_q.pop_front());
            void'(lat_q.pop_front());
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] prev;
        int cyc;
        int ndone;
        logic [1:0] ro;
        logic [31:0] ra, rb;

        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", result, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'h0000_000E);
        run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 32'h0000_0002);
        run_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_op("div_7_m2", 2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
        run_op("divu_5_0", 2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF);
        run_op("remu_5_0", 2'b11, 32'd5, 32'd0, 32'h0000_0005);
        run_op("div_m5_0", 2'b00, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF);
        run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
        run_op("divu_big", 2'b01, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF);
        run_op("rem_m_m", 2'b10, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE);

        for (int i = 0; i < 6; i++) begin
            ro = 2'($urandom);
            ra = $urandom;
            rb = (i == 5) ? 32'd3 : $urandom >> (i * 5);
            run_op("rand", ro, ra, rb, model(ro, ra, rb));
        end

        // Flush mid-CALC: no done, result untouched, next op completes normally.
        prev = result;
        @(negedge clk);
        op = 2'b01; dividend = 32'd1000; divisor = 32'd9; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_done", 32'(done), 32'd0);
        check("flush_result", result, prev);
        run_op("after_flush", 2'b01, 32'd1000, 32'd9, 32'd111);

        // Flush and start together in IDLE: the start is dropped.
        @(negedge clk);
        op = 2'b01; dividend = 32'd50; divisor = 32'd5; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1; start = 1'b0; flush = 1'b0;
        check("flush_start_busy", 32'(busy), 32'd0);
        ndone = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("flush_start_nodone", 32'(ndone), 32'd0);

        // Start while busy is ignored; only the original operands complete.
        @(negedge clk);
        op = 2'b01; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        cyc = 1;
        repeat (3) begin @(posedge clk); #1; cyc++; end
        @(negedge clk);
        op = 2'b00; dividend = 32'd77; divisor = 32'd7; start = 1'b1;
        @(posedge clk); #1; start = 1'b0; cyc++;
        while (!done && cyc < 100) begin @(posedge clk); #1; cyc++; end
        check("busy_start_latency", 32'(cyc), 32'd34);
        check("busy_start_result", result, 32'd333);
        ndone = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("busy_start_single_done", 32'(ndone), 32'd0);

        // Asynchronous reset mid-CALC clears outputs without waiting for a clock.
        @(negedge clk);
        op = 2'b01; dividend = 32'd999; divisor = 32'd4; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_result", result, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        ndone = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("arst_nodone", 32'(ndone), 32'd0);
        run_op("after_reset", 2'b00, 32'hFFFF_FF00, 32'd16, 32'hFFFF_FFF0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
